// File: rtl/spi_bitrev_pkg.sv
// spi_bitrev_pkg: shared FSM states, mode bit positions, pin bundle
// and the bit-reversal helper for the SPI bit-reversal slave.
package spi_bitrev_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT
    } state_t;

    localparam int CPOL_BIT = 1;
    localparam int CPHA_BIT = 0;

    typedef struct packed {
        logic sck;
        logic ss;
        logic mosi;
    } spi_pins_t;

    // Reverses the low n bits of w; bits at and above n come back zero.
    function automatic logic [31:0] bitrev(
        input logic [31:0] w,
        input int          n
    );
        logic [31:0] src;
        logic [31:0] r;
        src = w;
        r   = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) begin
                r   = {r[30:0], src[0]};
                src = src >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_bitrev_slave_sync.sv
// spi_pin_sync: multi-stage synchroniser for sck/ss/mosi with
// rise/fall pulses on the synchronised sck and ss.
module spi_pin_sync
    import spi_bitrev_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic sck,
    input  logic ss,
    input  logic mosi,
    output logic ss_s,
    output logic mosi_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_rise,
    output logic ss_fall
);

    spi_pins_t q [SYNC_STAGES];
    logic      sck_d;
    logic      ss_d;

    // Left unreset so ss is already settled when reset releases.
    always_ff @(posedge clock) begin
        q[0] <= spi_pins_t'{sck: sck, ss: ss, mosi: mosi};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            q[i] <= q[i-1];
        end
        sck_d <= q[SYNC_STAGES-1].sck;
        ss_d  <= q[SYNC_STAGES-1].ss;
    end

    assign ss_s     = q[SYNC_STAGES-1].ss;
    assign mosi_s   = q[SYNC_STAGES-1].mosi;
    assign sck_rise =  q[SYNC_STAGES-1].sck & ~sck_d;
    assign sck_fall = ~q[SYNC_STAGES-1].sck &  sck_d;
    assign ss_rise  =  q[SYNC_STAGES-1].ss  & ~ss_d;
    assign ss_fall  = ~q[SYNC_STAGES-1].ss  &  ss_d;

endmodule

// File: rtl/spi_bitrev_slave.sv
// spi_bitrev_slave: oversampled SPI slave echoing each word bit-reversed
// in the next slot. SPI_BITREV_RXPORT_EN adds rx_valid/rx_data ports.
module spi_bitrev_slave
    import spi_bitrev_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int MODE        = 0,
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_W     = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               sck,
    input  logic               ss,
    input  logic               mosi,
    output logic               miso,
    output logic               busy,
    output logic [COUNT_W-1:0] word_cnt
`ifdef SPI_BITREV_RXPORT_EN
    ,
    output logic               rx_valid,
    output logic [DATA_W-1:0]  rx_data
`endif
);

    localparam bit CPOL = MODE[CPOL_BIT];
    localparam bit CPHA = MODE[CPHA_BIT];
    localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     tx_idx;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] t_rev;

    logic ss_s, mosi_s;
    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic lead, trail, samp, shft, last_bit;

    spi_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .sck     (sck),
        .ss      (ss),
        .mosi    (mosi),
        .ss_s    (ss_s),
        .mosi_s  (mosi_s),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall),
        .ss_rise (ss_rise),
        .ss_fall (ss_fall)
    );

    assign lead     = CPOL ? sck_fall : sck_rise;
    assign trail    = CPOL ? sck_rise : sck_fall;
    assign samp     = CPHA ? trail : lead;
    assign shft     = CPHA ? lead : trail;
    assign r_word   = {rx_sr, mosi_s};
    assign last_bit = (bit_cnt == BW'(DATA_W-1));
    // t_rev holds the master's view, so slot bit i sits at DATA_W-1-i.
    assign tx_idx   = BW'(DATA_W-1) - bit_cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            miso     <= 1'b1;
            busy     <= 1'b0;
            word_cnt <= '0;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            t_rev    <= '0;
`ifdef SPI_BITREV_RXPORT_EN
            rx_valid <= 1'b0;
            rx_data  <= '0;
`endif
        end else begin
`ifdef SPI_BITREV_RXPORT_EN
            rx_valid <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= ACTIVE;
                        busy     <= 1'b1;
                        miso     <= 1'b0;
                        word_cnt <= '0;
                        bit_cnt  <= '0;
                        rx_sr    <= '0;
                        t_rev    <= '0;
                    end else if (!ss_s) begin
                        // ss was already low when reset released
                        state <= ABORT;
                        miso  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        miso  <= 1'b1;
                    end else if (samp) begin
                        rx_sr <= r_word[DATA_W-2:0];
                        if (last_bit) begin
                            bit_cnt <= '0;
                            t_rev   <= DATA_W'(bitrev(32'(r_word), DATA_W));
                            if (word_cnt != '1) begin
                                word_cnt <= word_cnt + 1'b1;
                            end
`ifdef SPI_BITREV_RXPORT_EN
                            rx_valid <= 1'b1;
                            rx_data  <= r_word;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (shft) begin
                        miso <= t_rev[tx_idx];
                    end
                end
                ABORT: begin
                    if (ss_rise) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    miso  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bitrev_slave.sv
// tb_spi_bitrev_slave: drives four slaves (mode/width variants) as an
// SPI master and checks reads and counters against a word-level model.
module tb_spi_bitrev_slave;

    localparam int N = 4;
    localparam int H = 6;
    localparam int DW [N] = '{8, 16, 16, 16};
    localparam int MD [N] = '{0, 3, 1, 2};
    localparam int CW [N] = '{4, 8, 8, 8};

    logic        clk = 1'b0;
    logic        resetn;
    logic        sck_w  [N];
    logic        ss_w   [N];
    logic        mosi_w [N];
    logic        miso_w [N];
    logic        busy_w [N];
    logic [31:0] cnt_w  [N];
`ifdef SPI_BITREV_RXPORT_EN
    logic        rxv_w  [N];
    logic [31:0] rxd_w  [N];
    int          rx_pulses = 0;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] wq [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [CW[g]-1:0] cnt;
`ifdef SPI_BITREV_RXPORT_EN
        logic [DW[g]-1:0] rxd;
        assign rxd_w[g] = 32'(rxd);
`endif
        spi_bitrev_slave #(
            .DATA_W     (DW[g]),
            .MODE       (MD[g]),
            .SYNC_STAGES(2),
            .COUNT_W    (CW[g])
        ) u_dut (
            .clock   (clk),
            .resetn  (resetn),
            .sck     (sck_w[g]),
            .ss      (ss_w[g]),
            .mosi    (mosi_w[g]),
            .miso    (miso_w[g]),
            .busy    (busy_w[g]),
            .word_cnt(cnt)
`ifdef SPI_BITREV_RXPORT_EN
            ,
            .rx_valid(rxv_w[g]),
            .rx_data (rxd)
`endif
        );
        assign cnt_w[g] = 32'(cnt);
    end

`ifdef SPI_BITREV_RXPORT_EN
    always @(negedge clk) begin
        if (rxv_w[0]) rx_pulses++;
    end
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] w, input int n);
        logic [31:0] r = 0;
        for (int i = 0; i < n; i++)
            r = r | (((w >> i) & 32'd1) << (n - 1 - i));
        return r;
    endfunction

    function automatic logic [31:0] mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic half();
        repeat (H) @(negedge clk);
    endtask

    // Master transfer of nbits of w (MSB first); returns bits read on miso.
    task automatic xfer(input int idx, input int nbits, input logic [31:0] w,
                        output logic [31:0] got);
        int          dw = DW[idx];
        int          m  = MD[idx];
        logic        cpol = m[1];
        logic        cpha = m[0];
        logic [31:0] tmp;
        got = 0;
        for (int i = 0; i < nbits; i++) begin
            tmp = w >> (dw - 1 - i);
            if (!cpha) begin
                mosi_w[idx] = tmp[0];
                half();
                got = {got[30:0], miso_w[idx]};
                sck_w[idx] = ~cpol;
                half();
                sck_w[idx] = cpol;
            end else begin
                sck_w[idx]  = ~cpol;
                mosi_w[idx] = tmp[0];
                half();
                got = {got[30:0], miso_w[idx]};
                sck_w[idx] = cpol;
                half();
            end
        end
    endtask

    // One full frame of the words in wq, checked against the model.
    task automatic frame(input int idx, input string nm);
        logic [31:0] prev = 0;
        logic [31:0] got;
        int          n   = wq.size();
        int          sat = (1 << CW[idx]) - 1;
        ss_w[idx] = 1'b0;
        half();
        foreach (wq[k]) begin
            xfer(idx, DW[idx], wq[k], got);
            check($sformatf("%s_d%0d_rd%0d", nm, idx, k), got,
                  rev(prev, DW[idx]));
            prev = wq[k];
        end
        check($sformatf("%s_d%0d_busy_in", nm, idx), 32'(busy_w[idx]), 1);
        half();
        ss_w[idx] = 1'b1;
        half();
        half();
        check($sformatf("%s_d%0d_cnt", nm, idx), cnt_w[idx],
              (n < sat) ? n : sat);
        check($sformatf("%s_d%0d_busy", nm, idx), 32'(busy_w[idx]), 0);
        check($sformatf("%s_d%0d_miso", nm, idx), 32'(miso_w[idx]), 1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        int          lat;
        int          m;
        int          p0;
        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin
            m         = MD[i];
            sck_w[i]  = m[1];
            ss_w[i]   = 1'b1;
            mosi_w[i] = 1'b0;
        end
        repeat (5) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_miso%0d", i), 32'(miso_w[i]), 1);
            check($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 0);
            check($sformatf("rst_cnt%0d", i), cnt_w[i], 0);
`ifdef SPI_BITREV_RXPORT_EN
            check($sformatf("rst_rxv%0d", i), 32'(rxv_w[i]), 0);
            check($sformatf("rst_rxd%0d", i), rxd_w[i], 0);
`endif
        end
        resetn = 1'b1;
        half();

        wq = '{32'h01, 32'h12, 32'hFF};
        frame(0, "m0");

        for (int i = 1; i < N; i++) begin
            wq = '{32'h1234, 32'h0000};
            frame(i, "w16");
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                wq = {};
                for (int k = 0; k < $urandom_range(1, 5); k++)
                    wq.push_back($urandom & mask(DW[i]));
                frame(i, "rnd");
            end
        end

        // ss raised part-way through the second word
        ss_w[0] = 1'b0;
        half();
        xfer(0, 8, $urandom & 32'hFF, got);
        xfer(0, 5, $urandom & 32'hFF, got);
        ss_w[0] = 1'b1;
        lat = 0;
        while (lat < 4 && miso_w[0] !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        check("abort_miso", 32'(miso_w[0]), 1);
        half();
        check("abort_cnt", cnt_w[0], 1);
        check("abort_busy", 32'(busy_w[0]), 0);
        wq = '{$urandom & 32'hFF, $urandom & 32'hFF};
        frame(0, "post_abort");

        wq = {};
        for (int k = 0; k < 20; k++) wq.push_back($urandom & 32'hFF);
        frame(0, "sat");

`ifdef SPI_BITREV_RXPORT_EN
        p0 = rx_pulses;
        wq = '{32'hC3};
        frame(0, "rx");
        check("rx_pulses", rx_pulses - p0, 1);
        check("rx_data", rxd_w[0], 32'hC3);
        ss_w[0] = 1'b0;
        half();
        xfer(0, 4, 32'hA5, got);
        half();
        ss_w[0] = 1'b1;
        half();
        half();
        check("rx_no_pulse", rx_pulses - p0, 1);
        check("rx_data_hold", rxd_w[0], 32'hC3);
`else
        p0 = 0;
`endif

        // reset mid-word with ss held low
        ss_w[0] = 1'b0;
        half();
        xfer(0, 3, 32'hFF, got);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("mrst_miso", 32'(miso_w[0]), 1);
        check("mrst_busy", 32'(busy_w[0]), 0);
        check("mrst_cnt", cnt_w[0] + 32'(p0), 32'(p0));
        resetn = 1'b1;
        half();
        xfer(0, 8, $urandom & 32'hFF, got);
        xfer(0, 8, $urandom & 32'hFF, got);
        half();
        check("ign_miso", 32'(miso_w[0]), 1);
        check("ign_busy", 32'(busy_w[0]), 0);
        check("ign_cnt", cnt_w[0], 0);
        ss_w[0] = 1'b1;
        half();
        half();
        wq = '{$urandom & 32'hFF, $urandom & 32'hFF, $urandom & 32'hFF};
        frame(0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
